// File: rtl/fmt_rx_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | fmt_rx_pkg : shared types and defaults for the packet receiver  |
// | rev 1.0                                                         |
// +-----------------------------------------------------------------+
package fmt_rx_pkg;

   localparam int C_DATA_W   = 32;
   localparam int C_LEN_W    = 6;
   localparam int C_MAX_LEN  = 32;
   localparam int C_DEPTH    = 64;
   localparam int C_START_TO = 16;

   typedef enum logic [1:0] {
      ST_IDLE       = 2'd0,
      ST_GRANT      = 2'd1,
      ST_WAIT_START = 2'd2,
      ST_RECV       = 2'd3
   } fmt_state_e;

   // Buffer entry layout at the default data width; the RAM stores it packed.
   typedef struct packed {
      logic [1:0]          chid;
      logic                sop;
      logic                eop;
      logic [C_DATA_W-1:0] data;
   } fmt_entry_t;

   function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
      return (en && (v != 16'hFFFF)) ? v + 16'd1 : v;
   endfunction

endpackage

`default_nettype wire

// File: rtl/fmt_rx_buf.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | fmt_rx_buf : packet RAM with speculative write, commit and read |
// | rev 1.0                                                         |
// +-----------------------------------------------------------------+
module fmt_rx_buf #(
   parameter int ENTRY_W = 36,
   parameter int DEPTH   = 64
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic                         wr_en_i,
   input  logic [ENTRY_W-1:0]           wr_entry_i,
   input  logic                         commit_i,
   input  logic                         rollback_i,
   input  logic                         rd_en_i,
   output logic [ENTRY_W-1:0]           rd_entry_o,
   output logic                         rd_vld_o,
   output logic [$clog2(DEPTH):0]       free_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;
   localparam logic [PW-1:0] C_DEPTH_P = PW'(DEPTH);

   logic [ENTRY_W-1:0] mem_q [DEPTH];
   logic [PW-1:0]      wr_spec_q,   wr_spec_d;
   logic [PW-1:0]      wr_commit_q, wr_commit_d;
   logic [PW-1:0]      rd_ptr_q,    rd_ptr_d;
   logic [PW-1:0]      wr_inc;
   logic [PW-1:0]      rd_inc;

   assign wr_inc     = {{(PW-1){1'b0}}, wr_en_i};
   assign rd_vld_o   = (rd_ptr_q != wr_commit_q);
   assign rd_inc     = {{(PW-1){1'b0}}, rd_en_i & rd_vld_o};
   assign rd_entry_o = mem_q[rd_ptr_q[AW-1:0]];
   // Only committed occupancy reduces space; speculative words ride in the slack.
   assign free_o     = C_DEPTH_P - (wr_commit_q - rd_ptr_q);

   always_comb begin
      wr_spec_d   = wr_spec_q + wr_inc;
      wr_commit_d = wr_commit_q;
      rd_ptr_d    = rd_ptr_q + rd_inc;
      if (rollback_i) begin
         wr_spec_d = wr_commit_q;
      end else if (commit_i) begin
         wr_commit_d = wr_spec_q + wr_inc;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_spec_q   <= '0;
         wr_commit_q <= '0;
         rd_ptr_q    <= '0;
      end else begin
         wr_spec_q   <= wr_spec_d;
         wr_commit_q <= wr_commit_d;
         rd_ptr_q    <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (wr_en_i) begin
         mem_q[wr_spec_q[AW-1:0]] <= wr_entry_i;
      end
   end

endmodule

`default_nettype wire

// File: rtl/fmt_pkt_rx.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | fmt_pkt_rx : formatter packet receiver with length check        |
// | rev 1.0                                                         |
// +-----------------------------------------------------------------+
module fmt_pkt_rx
   import fmt_rx_pkg::*;
#(
   parameter int DATA_W   = C_DATA_W,
   parameter int LEN_W    = C_LEN_W,
   parameter int MAX_LEN  = C_MAX_LEN,
   parameter int DEPTH    = C_DEPTH,
   parameter int START_TO = C_START_TO
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              fmt_req_i,
   input  logic [1:0]        fmt_chid_i,
   input  logic [LEN_W-1:0]  fmt_length_i,
   output logic              fmt_grant_o,
   input  logic [DATA_W-1:0] fmt_data_i,
   input  logic              fmt_start_i,
   input  logic              fmt_end_i,
   output logic              out_vld_o,
   input  logic              out_rdy_i,
   output logic [DATA_W-1:0] out_data_o,
   output logic              out_sop_o,
   output logic              out_eop_o,
   output logic [1:0]        out_chid_o,
   output logic [15:0]       pkt_cnt_o,
   output logic [15:0]       drop_cnt_o
);

   localparam int PW      = $clog2(DEPTH) + 1;
   localparam int CNT_W   = LEN_W + 1;
   localparam int TO_W    = $clog2(START_TO) + 1;
   localparam int ENTRY_W = DATA_W + 4;

   fmt_state_e          state_q, state_d;
   logic                grant_q, grant_d;
   logic [1:0]          chid_q, chid_d;
   logic [LEN_W-1:0]    len_q, len_d;
   logic                bad_q, bad_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [TO_W-1:0]     to_q, to_d;
   logic [15:0]         pkt_cnt_q, pkt_cnt_d;
   logic [15:0]         drop_cnt_q, drop_cnt_d;

   logic                word_vld;
   logic [CNT_W-1:0]    cnt_base;
   logic [CNT_W-1:0]    cnt_new;
   logic [CNT_W-1:0]    len_ext;
   logic                wr_en;
   logic                commit;
   logic                rollback;
   logic                pkt_inc;
   logic                drop_inc;
   logic [ENTRY_W-1:0]  wr_entry;
   logic [ENTRY_W-1:0]  rd_entry;
   logic                rd_vld;
   logic [PW-1:0]       free;

   assign word_vld = ((state_q == ST_WAIT_START) && fmt_start_i) || (state_q == ST_RECV);
   assign cnt_base = (state_q == ST_WAIT_START) ? '0 : cnt_q;
   // Saturate so a runaway packet can never alias back onto its length.
   assign cnt_new  = (cnt_base == {CNT_W{1'b1}}) ? cnt_base : cnt_base + 1'b1;
   assign len_ext  = {1'b0, len_q};
   assign wr_en    = word_vld && !bad_q && (cnt_base < len_ext);
   assign wr_entry = {chid_q, (cnt_base == '0), (cnt_new == len_ext), fmt_data_i};

   always_comb begin
      state_d    = state_q;
      grant_d    = 1'b0;
      chid_d     = chid_q;
      len_d      = len_q;
      bad_d      = bad_q;
      cnt_d      = cnt_q;
      to_d       = to_q;
      commit     = 1'b0;
      rollback   = 1'b0;
      pkt_inc    = 1'b0;
      drop_inc   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (fmt_req_i && (32'(free) >= 32'(fmt_length_i))) begin
               chid_d  = fmt_chid_i;
               len_d   = fmt_length_i;
               bad_d   = (fmt_length_i == '0) || (32'(fmt_length_i) > MAX_LEN);
               grant_d = 1'b1;
               state_d = ST_GRANT;
            end
         end
         ST_GRANT: begin
            to_d    = '0;
            state_d = ST_WAIT_START;
         end
         ST_WAIT_START: begin
            if (!fmt_start_i) begin
               if (to_q == TO_W'(START_TO - 1)) begin
                  drop_inc = 1'b1;
                  state_d  = ST_IDLE;
               end else begin
                  to_d = to_q + 1'b1;
               end
            end
         end
         default: ;
      endcase

      if (word_vld) begin
         if (fmt_end_i) begin
            if ((cnt_new == len_ext) && !bad_q) begin
               commit  = 1'b1;
               pkt_inc = 1'b1;
            end else begin
               rollback = 1'b1;
               drop_inc = 1'b1;
            end
            state_d = ST_IDLE;
         end else begin
            cnt_d   = cnt_new;
            state_d = ST_RECV;
         end
      end

      pkt_cnt_d  = sat_inc(pkt_cnt_q, pkt_inc);
      drop_cnt_d = sat_inc(drop_cnt_q, drop_inc);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= ST_IDLE;
         grant_q    <= 1'b0;
         chid_q     <= '0;
         len_q      <= '0;
         bad_q      <= 1'b0;
         cnt_q      <= '0;
         to_q       <= '0;
         pkt_cnt_q  <= '0;
         drop_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         chid_q     <= chid_d;
         len_q      <= len_d;
         bad_q      <= bad_d;
         cnt_q      <= cnt_d;
         to_q       <= to_d;
         pkt_cnt_q  <= pkt_cnt_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   fmt_rx_buf #(
      .ENTRY_W (ENTRY_W),
      .DEPTH   (DEPTH)
   ) u_buf (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .wr_en_i    (wr_en),
      .wr_entry_i (wr_entry),
      .commit_i   (commit),
      .rollback_i (rollback),
      .rd_en_i    (out_rdy_i),
      .rd_entry_o (rd_entry),
      .rd_vld_o   (rd_vld),
      .free_o     (free)
   );

   // RAM contents are unreset, so the data path is forced to zero while empty.
   assign fmt_grant_o = grant_q;
   assign out_vld_o   = rd_vld;
   assign out_chid_o  = rd_vld ? rd_entry[DATA_W+3:DATA_W+2] : 2'b00;
   assign out_sop_o   = rd_vld & rd_entry[DATA_W+1];
   assign out_eop_o   = rd_vld & rd_entry[DATA_W];
   assign out_data_o  = rd_vld ? rd_entry[DATA_W-1:0] : '0;
   assign pkt_cnt_o   = pkt_cnt_q;
   assign drop_cnt_o  = drop_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_fmt_pkt_rx.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | tb_fmt_pkt_rx : vector table, random traffic and corner cases   |
// | rev 1.0                                                         |
// +-----------------------------------------------------------------+
module tb_fmt_pkt_rx;

   localparam int MAX_LEN = 32;

   logic        clk = 1'b0;
   logic        rst_i = 1'b1;
   logic        fmt_req_i = 1'b0;
   logic [1:0]  fmt_chid_i = '0;
   logic [5:0]  fmt_length_i = '0;
   logic        fmt_grant_o;
   logic [31:0] fmt_data_i = '0;
   logic        fmt_start_i = 1'b0;
   logic        fmt_end_i = 1'b0;
   logic        out_vld_o;
   logic        out_rdy_i = 1'b1;
   logic [31:0] out_data_o;
   logic        out_sop_o;
   logic        out_eop_o;
   logic [1:0]  out_chid_o;
   logic [15:0] pkt_cnt_o;
   logic [15:0] drop_cnt_o;

   always #5 clk = ~clk;

   fmt_pkt_rx dut (
      .clk_i        (clk),
      .rst_i        (rst_i),
      .fmt_req_i    (fmt_req_i),
      .fmt_chid_i   (fmt_chid_i),
      .fmt_length_i (fmt_length_i),
      .fmt_grant_o  (fmt_grant_o),
      .fmt_data_i   (fmt_data_i),
      .fmt_start_i  (fmt_start_i),
      .fmt_end_i    (fmt_end_i),
      .out_vld_o    (out_vld_o),
      .out_rdy_i    (out_rdy_i),
      .out_data_o   (out_data_o),
      .out_sop_o    (out_sop_o),
      .out_eop_o    (out_eop_o),
      .out_chid_o   (out_chid_o),
      .pkt_cnt_o    (pkt_cnt_o),
      .drop_cnt_o   (drop_cnt_o)
   );

   typedef struct packed {
      logic [1:0]  chid;
      logic        sop;
      logic        eop;
      logic [31:0] data;
   } exp_t;

   typedef struct {
      logic [1:0] chid;
      logic [5:0] len;
      int         nw;
      int         exp_pkt;
      int         exp_drop;
   } vec_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   exp_pkt  = 0;
   int   exp_drop = 0;
   int   n_chk    = 0;
   int   n_pass   = 0;
   bit   rand_rdy = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      if (rand_rdy) out_rdy_i = 1'($urandom_range(0, 1));
   endtask

   // Scoreboard: every accepted output word must be the next expected one.
   always @(negedge clk) begin
      if (!rst_i && out_vld_o && out_rdy_i) begin
         if (exp_q.size() == 0) begin
            chk("out_word_unexpected", {28'd0, out_chid_o, out_sop_o, out_eop_o, out_data_o}, 64'd0);
         end else begin
            mon_e = exp_q.pop_front();
            chk("out_word", {28'd0, out_chid_o, out_sop_o, out_eop_o, out_data_o}, {28'd0, mon_e});
         end
      end
   end

   // Called with grant visible; drives words from the first WAIT_START cycle.
   task automatic send_words(input logic [1:0] ch, input logic [5:0] len, input int nw);
      exp_t w[$];
      logic [31:0] d;
      tick();
      chk("grant_pulse_width", fmt_grant_o, 0);
      for (int i = 0; i < nw; i++) begin
         d = $urandom;
         fmt_start_i = (i == 0);
         fmt_end_i   = (i == nw - 1);
         fmt_data_i  = d;
         if (i < int'(len)) w.push_back({ch, (i == 0), (i == int'(len) - 1), d});
         tick();
      end
      fmt_start_i = 1'b0;
      fmt_end_i   = 1'b0;
      fmt_data_i  = '0;
      if (len >= 1 && int'(len) <= MAX_LEN && nw == int'(len)) begin
         foreach (w[k]) exp_q.push_back(w[k]);
         exp_pkt++;
      end else begin
         exp_drop++;
      end
   endtask

   task automatic send_pkt(input logic [1:0] ch, input logic [5:0] len, input int nw, output int lat);
      fmt_req_i    = 1'b1;
      fmt_chid_i   = ch;
      fmt_length_i = len;
      tick();
      lat = 1;
      while (!fmt_grant_o && lat < 400) begin
         tick();
         lat++;
      end
      fmt_req_i = 1'b0;
      if (!fmt_grant_o) chk("grant_wait_expired", 0, 1);
      else if (nw > 0) send_words(ch, len, nw);
   endtask

   task automatic wait_drain();
      int n = 0;
      while ((exp_q.size() != 0 || out_vld_o) && n < 3000) begin
         tick();
         n++;
      end
      chk("drain", (exp_q.size() == 0) && !out_vld_o, 1);
   endtask

   initial begin
      #900_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs[8];
      int   lat;
      int   seen;
      logic [5:0] len;
      int   nw;

      vecs[0] = '{2'd1, 6'd4,  4,  1, 0};
      vecs[1] = '{2'd2, 6'd8,  6,  1, 1};
      vecs[2] = '{2'd0, 6'd1,  1,  2, 1};
      vecs[3] = '{2'd3, 6'd32, 32, 3, 1};
      vecs[4] = '{2'd1, 6'd0,  1,  3, 2};
      vecs[5] = '{2'd2, 6'd40, 40, 3, 3};
      vecs[6] = '{2'd0, 6'd4,  6,  3, 4};
      vecs[7] = '{2'd3, 6'd5,  5,  4, 4};

      repeat (3) tick();
      chk("rst_grant", fmt_grant_o, 0);
      chk("rst_vld",   out_vld_o, 0);
      chk("rst_data",  out_data_o, 0);
      chk("rst_flags", {out_sop_o, out_eop_o, out_chid_o}, 0);
      chk("rst_pkt",   pkt_cnt_o, 0);
      chk("rst_drop",  drop_cnt_o, 0);
      rst_i = 1'b0;
      tick();

      // Table of single packets with hand-computed cumulative counters.
      for (int i = 0; i < 8; i++) begin
         send_pkt(vecs[i].chid, vecs[i].len, vecs[i].nw, lat);
         if (i == 0) chk("grant_latency", lat, 1);
         wait_drain();
         chk("vec_pkt_cnt",  pkt_cnt_o,  vecs[i].exp_pkt);
         chk("vec_drop_cnt", drop_cnt_o, vecs[i].exp_drop);
      end

      // Random traffic with a 50% ready; first packets are back-to-back 32s to wrap pointers.
      rand_rdy = 1'b1;
      for (int k = 0; k < 40; k++) begin
         if (k < 6) len = 6'd32;
         else if ($urandom_range(0, 9) == 0) len = 6'($urandom_range(0, 40));
         else len = 6'($urandom_range(1, 32));
         if (len == 0 || $urandom_range(0, 3) == 0) nw = $urandom_range(1, 34);
         else nw = int'(len);
         send_pkt(2'($urandom_range(0, 3)), len, nw, lat);
      end
      wait_drain();
      rand_rdy  = 1'b0;
      out_rdy_i = 1'b1;
      chk("rand_pkt_cnt",  pkt_cnt_o,  exp_pkt);
      chk("rand_drop_cnt", drop_cnt_o, exp_drop);

      // Space check: 40 committed words leave 24 free, too few for 32.
      out_rdy_i = 1'b0;
      send_pkt(2'd1, 6'd32, 32, lat);
      send_pkt(2'd2, 6'd8, 8, lat);
      fmt_req_i    = 1'b1;
      fmt_chid_i   = 2'd3;
      fmt_length_i = 6'd32;
      seen = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (fmt_grant_o) seen++;
      end
      chk("no_grant_when_full", seen, 0);
      out_rdy_i = 1'b1;
      repeat (8) tick();
      out_rdy_i = 1'b0;
      tick();
      chk("grant_after_drain", fmt_grant_o, 1);
      fmt_req_i = 1'b0;
      send_words(2'd3, 6'd32, 32);
      out_rdy_i = 1'b1;
      wait_drain();
      chk("space_pkt_cnt", pkt_cnt_o, exp_pkt);

      // Start timeout after grant.
      send_pkt(2'd0, 6'd4, 0, lat);
      repeat (20) tick();
      exp_drop++;
      chk("timeout_drop_cnt", drop_cnt_o, exp_drop);
      send_pkt(2'd0, 6'd4, 4, lat);
      wait_drain();
      chk("after_timeout_pkt_cnt", pkt_cnt_o, exp_pkt);

      // Reset in the middle of a packet with committed data waiting.
      out_rdy_i = 1'b0;
      send_pkt(2'd1, 6'd4, 4, lat);
      chk("pre_rst_vld", out_vld_o, 1);
      send_pkt(2'd2, 6'd8, 0, lat);
      tick();
      for (int i = 0; i < 3; i++) begin
         fmt_start_i = (i == 0);
         fmt_data_i  = $urandom;
         tick();
      end
      fmt_start_i = 1'b0;
      rst_i = 1'b1;
      tick();
      exp_q.delete();
      exp_pkt  = 0;
      exp_drop = 0;
      chk("mid_rst_vld",   out_vld_o, 0);
      chk("mid_rst_data",  out_data_o, 0);
      chk("mid_rst_flags", {out_sop_o, out_eop_o, out_chid_o, fmt_grant_o}, 0);
      chk("mid_rst_cnts",  {pkt_cnt_o, drop_cnt_o}, 0);
      rst_i     = 1'b0;
      out_rdy_i = 1'b1;
      for (int i = 0; i < 5; i++) begin
         fmt_start_i = (i == 0);
         fmt_end_i   = (i == 4);
         fmt_data_i  = $urandom;
         tick();
      end
      fmt_start_i = 1'b0;
      fmt_end_i   = 1'b0;
      repeat (3) tick();
      chk("trailing_ignored_vld",  out_vld_o, 0);
      chk("trailing_ignored_cnts", {pkt_cnt_o, drop_cnt_o}, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

`default_nettype wire
